// File: rtl/jpeg_pkg.sv
// Shared JPEG block types and constants: zigzag scan table, block length,
// output beat struct and the capture-side FSM state encoding.
package jpeg_pkg;

  localparam int BLOCK_LEN = 64;
  localparam int ZZ_DATA_W = 12;

  // Raster address (8*row+col) of each zigzag scan position.
  localparam logic [5:0] ZZ_ORDER [BLOCK_LEN] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  typedef struct packed {
    logic [ZZ_DATA_W-1:0] data;
    logic                 sop;
    logic                 eop;
    logic                 valid;
  } zz_beat_t;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_FILL = 2'd1,
    WR_DROP = 2'd2
  } wr_state_t;

endpackage

// File: rtl/zz_bank_ram.sv
// Block buffer storage: NUM_BANKS x 64 coefficients, simple dual port,
// synchronous write and synchronous read (read data holds while re=0).
module zz_bank_ram
  import jpeg_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int NUM_BANKS  = 2,
  parameter int AW         = 7
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [NUM_BANKS*BLOCK_LEN];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/dct_zigzag_buffer.sv
// Captures raster-order 8x8 DCT blocks into a bank FIFO and replays them in
// zigzag order. Optional macro ZIGZAG_NZ_COUNT_EN adds out_nz_count per block.
module dct_zigzag_buffer
  import jpeg_pkg::*;
#(
  parameter int DATA_WIDTH = ZZ_DATA_W,
  parameter int NUM_BANKS  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  err_drop,
  output logic                  banks_full,
`ifdef ZIGZAG_NZ_COUNT_EN
  output logic [6:0]            out_nz_count,
`endif
  output wr_state_t             dbg_wr_state
);

  localparam int BW = $clog2(NUM_BANKS);
  localparam int AW = BW + 6;
  localparam int CW = $clog2(NUM_BANKS + 1);

  function automatic logic [BW-1:0] bump(input logic [BW-1:0] p);
    return (p == BW'(NUM_BANKS - 1)) ? '0 : p + BW'(1);
  endfunction

  wr_state_t             wr_state, wr_state_n;
  logic [5:0]            wcnt, wcnt_n, ram_woff, zcnt;
  logic [BW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         used, ready_cnt;
  logic                  ram_we, commit, set_err;
  logic                  advance, issue, last_issue, free_now, bank_free;
  logic                  ov_q, sop_q, eop_q;
  logic [DATA_WIDTH-1:0] rd_data;
  zz_beat_t              beat_o;

  // Output handshake: a beat transfers on out_valid & out_ready; while
  // out_valid & !out_ready the whole beat is held unchanged.
  assign free_now   = ov_q & out_ready & eop_q;
  assign bank_free  = (used != CW'(NUM_BANKS)) | free_now;
  assign advance    = !ov_q | out_ready;
  assign issue      = advance & (ready_cnt != '0);
  assign last_issue = issue & (zcnt == 6'd63);
  assign banks_full = (used == CW'(NUM_BANKS));
  assign dbg_wr_state = wr_state;

  always_comb begin
    wr_state_n = wr_state;
    wcnt_n     = wcnt;
    ram_we     = 1'b0;
    ram_woff   = wcnt;
    commit     = 1'b0;
    set_err    = 1'b0;
    case (wr_state)
      WR_IDLE, WR_DROP: begin
        if (in_valid && in_sop) begin
          if (bank_free) begin
            ram_we     = 1'b1;
            ram_woff   = 6'd0;
            wcnt_n     = 6'd1;
            wr_state_n = WR_FILL;
          end else begin
            set_err    = 1'b1;
            wr_state_n = WR_DROP;
          end
        end else if (wr_state == WR_DROP && in_valid && in_eop) begin
          wr_state_n = WR_IDLE;
        end
      end
      WR_FILL: begin
        if (in_valid) begin
          if (in_sop) begin
            // Restart the partial block in the same bank.
            set_err  = 1'b1;
            ram_we   = 1'b1;
            ram_woff = 6'd0;
            wcnt_n   = 6'd1;
          end else if (wcnt == 6'd63) begin
            ram_we     = in_eop;
            commit     = in_eop;
            set_err    = !in_eop;
            wr_state_n = WR_IDLE;
          end else if (in_eop) begin
            set_err    = 1'b1;
            wr_state_n = WR_IDLE;
          end else begin
            ram_we = 1'b1;
            wcnt_n = wcnt + 6'd1;
          end
        end
      end
      default: wr_state_n = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state  <= WR_IDLE;
      wcnt      <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      used      <= '0;
      ready_cnt <= '0;
      zcnt      <= '0;
      ov_q      <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      err_drop  <= 1'b0;
    end else begin
      wr_state <= wr_state_n;
      wcnt     <= wcnt_n;
      if (set_err) err_drop <= 1'b1;
      if (commit) wr_ptr <= bump(wr_ptr);
      // used: banks not free; ready_cnt: committed banks not yet fully issued.
      if (commit != free_now) used <= commit ? used + CW'(1) : used - CW'(1);
      if (commit != last_issue)
        ready_cnt <= commit ? ready_cnt + CW'(1) : ready_cnt - CW'(1);
      if (advance) begin
        ov_q  <= issue;
        sop_q <= issue & (zcnt == 6'd0);
        eop_q <= last_issue;
      end
      if (issue) zcnt <= zcnt + 6'd1;
      if (last_issue) rd_ptr <= bump(rd_ptr);
    end
  end

  zz_bank_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_BANKS (NUM_BANKS),
    .AW        (AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr({wr_ptr, ram_woff}),
    .wdata(in_data),
    .re   (issue),
    .raddr({rd_ptr, ZZ_ORDER[zcnt]}),
    .rdata(rd_data)
  );

  always_comb begin
    beat_o.data  = ov_q ? rd_data : '0;
    beat_o.sop   = sop_q;
    beat_o.eop   = eop_q;
    beat_o.valid = ov_q;
  end

  assign out_data  = beat_o.data;
  assign out_sop   = beat_o.sop;
  assign out_eop   = beat_o.eop;
  assign out_valid = beat_o.valid;

`ifdef ZIGZAG_NZ_COUNT_EN
  logic [6:0] nz_cnt, nz_q;
  logic [6:0] nz_bank [NUM_BANKS];
  logic       nz_bit;

  assign nz_bit = (in_data != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      nz_cnt <= '0;
      nz_q   <= '0;
    end else begin
      if (ram_we) nz_cnt <= ((ram_woff == 6'd0) ? 7'd0 : nz_cnt) + {6'd0, nz_bit};
      if (issue && zcnt == 6'd0) nz_q <= nz_bank[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (commit) nz_bank[wr_ptr] <= nz_cnt + {6'd0, nz_bit};
  end

  assign out_nz_count = nz_q;
`endif

endmodule

// File: tb/tb_dct_zigzag_buffer.sv
// Directed bench for dct_zigzag_buffer: diagonal-walk zigzag model, scoreboard
// queue checked on every accepted beat, plus hold, latency and framing checks.
module tb_dct_zigzag_buffer;
  import jpeg_pkg::*;

  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_sop = 1'b0, in_eop = 1'b0, in_valid = 1'b0;
  logic [W-1:0] out_data;
  logic         out_sop, out_eop, out_valid;
  logic         out_ready = 1'b1;
  logic         err_drop, banks_full;
  wr_state_t    dbg_state;
`ifdef ZIGZAG_NZ_COUNT_EN
  logic [6:0]   out_nz_count;
  int           exp_nz_q[$];
`endif

  dct_zigzag_buffer #(.DATA_WIDTH(W), .NUM_BANKS(2)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop), .in_valid(in_valid),
    .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
    .out_valid(out_valid), .out_ready(out_ready),
    .err_drop(err_drop), .banks_full(banks_full),
`ifdef ZIGZAG_NZ_COUNT_EN
    .out_nz_count(out_nz_count),
`endif
    .dbg_wr_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- reference model ----------------
  int zz_model[64];

  initial begin
    int k;
    k = 0;
    for (int s = 0; s < 15; s++) begin
      for (int t = 0; t < 8; t++) begin
        int row, col;
        row = (s % 2 == 0) ? s - t : t;
        col = s - row;
        if (row >= 0 && row < 8 && col >= 0 && col < 8) begin
          zz_model[k] = row * 8 + col;
          k++;
        end
      end
    end
  end

  logic [W+1:0] exp_q[$];

  task automatic expect_block(input int base);
    logic [W-1:0] d;
    int nz;
    nz = 0;
    for (int z = 0; z < 64; z++) begin
      d = W'(base + zz_model[z]);
      exp_q.push_back({(z == 0), (z == 63), d});
      if (d != '0) nz++;
    end
`ifdef ZIGZAG_NZ_COUNT_EN
    exp_nz_q.push_back(nz);
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_beat(input logic [W-1:0] d, input logic s, input logic e);
    @(posedge clk); #1;
    in_data = d; in_sop = s; in_eop = e; in_valid = 1'b1;
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0;
  endtask

  task automatic send_beats(input int base, input int n, input int eop_idx);
    for (int r = 0; r < n; r++) drive_beat(W'(base + r), (r == 0), (r == eop_idx));
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard / compare process ----------------
  int           acc_cnt = 0;
  int           first_acc = -1, last_acc = -1, first_valid = -1;
  int           got[64];
  logic         hold_pend = 1'b0;
  logic [W+2:0] hold_val;

  always @(negedge clk) begin
    logic [W+1:0] e;
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend)
        check("hold_stable", {out_data, out_sop, out_eop, out_valid}, hold_val);
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (out_valid && out_ready) begin
        if (acc_cnt < 64) got[acc_cnt] = out_data;
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        acc_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("beat", {out_sop, out_eop, out_data}, e);
        end
`ifdef ZIGZAG_NZ_COUNT_EN
        if (out_sop) begin
          if (exp_nz_q.size() == 0) check("nz_unexpected", 1, 0);
          else check("nz_count", out_nz_count, exp_nz_q.pop_front());
        end
`endif
      end
      hold_pend = out_valid && !out_ready;
      hold_val  = {out_data, out_sop, out_eop, out_valid};
    end
  end

  task automatic clear_stats();
    acc_cnt = 0; first_acc = -1; last_acc = -1; first_valid = -1;
  endtask

  // ---------------- tests ----------------
  int eop_cyc;
  int pin[10] = '{0, 1, 8, 16, 9, 2, 3, 10, 17, 24};

  initial begin
    do_reset();
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sop", out_sop, 0);
    check("rst_out_eop", out_eop, 0);
    check("rst_out_data", out_data, 0);
    check("rst_err_drop", err_drop, 0);
    check("rst_banks_full", banks_full, 0);

    // Pin the model against the well-known table head and tail.
    for (int i = 0; i < 10; i++) check($sformatf("model_zz%0d", i), zz_model[i], pin[i]);
    check("model_zz63", zz_model[63], 63);

    // Single block, data = raster index.
    clear_stats();
    expect_block(0);
    send_beats(0, 64, 63);
    go_idle();
    eop_cyc = cyc;
    wait_drain("drain_single", 300);
    check("single_latency", first_valid, eop_cyc + 1);
    check("single_count", acc_cnt, 64);
    check("single_got2", got[2], 8);
    check("single_got10", got[10], 32);
    check("single_got63", got[63], 63);

    // Three back-to-back blocks, no gaps.
    clear_stats();
    for (int b = 0; b < 3; b++) expect_block(b * 256);
    for (int b = 0; b < 3; b++) send_beats(b * 256, 64, 63);
    go_idle();
    wait_drain("drain_b2b", 400);
    check("b2b_count", acc_cnt, 192);
    check("b2b_no_gap", last_acc - first_acc, 191);
    check("b2b_err_drop", err_drop, 0);

    // Consumer stalled: two blocks stored, third dropped.
    do_reset();
    clear_stats();
    out_ready = 1'b0;
    expect_block(16);
    expect_block(512);
    send_beats(16, 64, 63);
    send_beats(512, 64, 63);
    send_beats(768, 64, 63);
    go_idle();
    repeat (3) @(posedge clk);
    #1;
    check("stall_banks_full", banks_full, 1);
    check("stall_err_drop", err_drop, 1);
    check("stall_no_accept", acc_cnt, 0);
    check("stall_out_valid", out_valid, 1);
    out_ready = 1'b1;
    wait_drain("drain_stall", 400);
    check("stall_count", acc_cnt, 128);
    check("stall_banks_free", banks_full, 0);

    // Early eop at raster 40 aborts the block.
    do_reset();
    clear_stats();
    send_beats(100, 41, 40);
    go_idle();
    repeat (6) @(posedge clk);
    #1;
    check("short_err_drop", err_drop, 1);
    check("short_no_output", acc_cnt, 0);
    expect_block(768);
    send_beats(768, 64, 63);
    go_idle();
    wait_drain("drain_after_short", 300);
    check("short_next_count", acc_cnt, 64);

    // sop re-asserted at index 20: only the restarted block comes out.
    do_reset();
    clear_stats();
    send_beats(200, 20, -1);
    expect_block(1024);
    send_beats(1024, 64, 63);
    go_idle();
    wait_drain("drain_resop", 300);
    check("resop_count", acc_cnt, 64);
    check("resop_err_drop", err_drop, 1);

    // Reset in the middle of output (zigzag index 30 on the port).
    do_reset();
    clear_stats();
    send_beats(5, 11, 10);
    go_idle();
    #1;
    check("mid_err_before", err_drop, 1);
    expect_block(300);
    send_beats(300, 64, 63);
    go_idle();
    begin
      int n;
      n = 0;
      while (acc_cnt < 30 && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      check("mid_reach_30", acc_cnt, 30);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_out_valid", out_valid, 0);
    check("mid_err_drop", err_drop, 0);
    exp_q.delete();
`ifdef ZIGZAG_NZ_COUNT_EN
    exp_nz_q.delete();
`endif
    clear_stats();
    expect_block(1500);
    send_beats(1500, 64, 63);
    go_idle();
    wait_drain("drain_after_mid", 300);
    check("mid_fresh_count", acc_cnt, 64);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
